// File: rtl/binary_gcd_if.sv
// Start/ready handshake bundle for the binary GCD engine.
// The host drives operands and control; the engine returns status and results.
interface binary_gcd_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             ready;
  logic             done_tick;
  logic [W-1:0]     r;
  logic             zero_err;
  logic             coprime;
  logic [CNT_W-1:0] cycles;

  modport master (
    output start, abort, a_in, b_in,
    input  ready, done_tick, r, zero_err, coprime, cycles
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output ready, done_tick, r, zero_err, coprime, cycles
  );
endinterface

// File: rtl/binary_gcd_unit.sv
// Binary (Stein) GCD engine: one reduction step per cycle, zero-operand short-cut,
// abortable, with a held result, coprime/zero flags and a saturating step count.
module binary_gcd_unit #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  binary_gcd_if.slave   bus
);

  localparam int N_W = $clog2(W) + 1;
  localparam logic [W-1:0]     ONE_W   = W'(1);
  localparam logic [N_W-1:0]   ONE_N   = N_W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, a_next;
  logic [W-1:0]     b_reg, b_next;
  logic [N_W-1:0]   n_reg, n_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [W-1:0]     r_reg, r_next;
  logic             zero_err_reg, zero_err_next;
  logic             coprime_reg, coprime_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;

  logic [W-1:0]     shifted;
  logic [W-1:0]     operand_or;
  logic [CNT_W-1:0] cnt_inc;

  // n never exceeds W-1 for nonzero operands, so the shift cannot drop bits.
  assign shifted    = a_reg << n_reg;
  assign operand_or = bus.a_in | bus.b_in;
  assign cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + ONE_CNT;

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    n_next        = n_reg;
    cnt_next      = cnt_reg;
    r_next        = r_reg;
    zero_err_next = zero_err_reg;
    coprime_next  = coprime_reg;
    cycles_next   = cycles_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next = bus.a_in;
          b_next = bus.b_in;
          if (bus.a_in == '0 || bus.b_in == '0) begin
            state_next    = DONE;
            r_next        = operand_or;
            zero_err_next = (operand_or == '0);
            coprime_next  = (operand_or == ONE_W);
            cycles_next   = '0;
          end else begin
            state_next = OP;
            n_next     = '0;
            cnt_next   = '0;
          end
        end
      end

      OP: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (a_reg == b_reg) begin
            state_next    = DONE;
            r_next        = shifted;
            zero_err_next = 1'b0;
            coprime_next  = (shifted == ONE_W);
            cycles_next   = cnt_inc;
          end else if (!a_reg[0] && !b_reg[0]) begin
            a_next = a_reg >> 1;
            b_next = b_reg >> 1;
            n_next = n_reg + ONE_N;
          end else if (!a_reg[0]) begin
            a_next = a_reg >> 1;
          end else if (!b_reg[0]) begin
            b_next = b_reg >> 1;
          end else if (a_reg > b_reg) begin
            a_next = a_reg - b_reg;
          end else begin
            b_next = b_reg - a_reg;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      n_reg        <= '0;
      cnt_reg      <= '0;
      r_reg        <= '0;
      zero_err_reg <= 1'b0;
      coprime_reg  <= 1'b0;
      cycles_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      n_reg        <= n_next;
      cnt_reg      <= cnt_next;
      r_reg        <= r_next;
      zero_err_reg <= zero_err_next;
      coprime_reg  <= coprime_next;
      cycles_reg   <= cycles_next;
    end
  end

  assign bus.ready     = (state_reg == IDLE);
  assign bus.done_tick = (state_reg == DONE);
  assign bus.r         = r_reg;
  assign bus.zero_err  = zero_err_reg;
  assign bus.coprime   = coprime_reg;
  assign bus.cycles    = cycles_reg;

endmodule

// File: tb/tb_binary_gcd_unit.sv
// Scoreboard bench for binary_gcd_unit: a W=32/CNT_W=16 and a W=8/CNT_W=4 instance,
// directed cases plus random pairs checked against an Euclid/step-rule reference.
module tb_binary_gcd_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  binary_gcd_if #(.W(32), .CNT_W(16)) bus32 ();
  binary_gcd_if #(.W(8),  .CNT_W(4))  bus8 ();

  binary_gcd_unit #(.W(32), .CNT_W(16)) u32 (.clk(clk), .reset(reset), .bus(bus32));
  binary_gcd_unit #(.W(8),  .CNT_W(4))  u8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    longint unsigned r;
    bit              ze;
    bit              cp;
    longint unsigned cy;
    int              lat;
    int              acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: Euclid for the value, the stated reduction rules for the step count.
  function automatic longint unsigned ref_gcd(longint unsigned a, longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int ref_steps(longint unsigned a, longint unsigned b);
    int k = 0;
    if (a == 0 || b == 0) return 0;
    forever begin
      k++;
      if (a == b) return k;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
  endfunction

  function automatic exp_t model(longint unsigned a, longint unsigned b, int cnt_w);
    exp_t e;
    longint unsigned sat;
    int k;
    sat   = (64'd1 << cnt_w) - 1;
    k     = ref_steps(a, b);
    e.r   = ref_gcd(a, b);
    e.ze  = (a == 0 && b == 0);
    e.cp  = (e.r == 1);
    e.cy  = (longint'(k) > sat) ? sat : longint'(k);
    e.lat = k + 1;
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(longint unsigned r, bit ze, bit cp, longint unsigned cy, int lat);
    exp_t e;
    e.r = r; e.ze = ze; e.cp = cp; e.cy = cy; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    while (bus32.ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("u32_ready_timeout", 0, 1);
    bus32.start = 1'b1; bus32.a_in = a; bus32.b_in = b;
    e.acc = cyc;
    if (push) q32.push_back(e);
    $display("u32 issue a=%0d b=%0d exp_r=%0d exp_cycles=%0d", a, b, e.r, e.cy);
    @(negedge clk);
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (bus8.ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("u8_ready_timeout", 0, 1);
    bus8.start = 1'b1; bus8.a_in = a; bus8.b_in = b;
    e.acc = cyc;
    q8.push_back(e);
    $display("u8 issue a=%0d b=%0d exp_r=%0d exp_cycles=%0d", a, b, e.r, e.cy);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic drain32();
    int n = 0;
    while ((q32.size() != 0 || bus32.ready !== 1'b1) && n < 5000) begin @(negedge clk); n++; end
    chk("u32_drain", q32.size(), 0);
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || bus8.ready !== 1'b1) && n < 5000) begin @(negedge clk); n++; end
    chk("u8_drain", q8.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus32.done_tick === 1'b1) begin
      if (q32.size() == 0) begin
        chk("u32_spurious_done", 1, 0);
      end else begin
        m32 = q32.pop_front();
        chk("u32_r", bus32.r, m32.r);
        chk("u32_zero_err", bus32.zero_err, m32.ze);
        chk("u32_coprime", bus32.coprime, m32.cp);
        chk("u32_cycles", bus32.cycles, m32.cy);
        chk("u32_latency", cyc - m32.acc, m32.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && bus8.done_tick === 1'b1) begin
      if (q8.size() == 0) begin
        chk("u8_spurious_done", 1, 0);
      end else begin
        m8 = q8.pop_front();
        chk("u8_r", bus8.r, m8.r);
        chk("u8_zero_err", bus8.zero_err, m8.ze);
        chk("u8_coprime", bus8.coprime, m8.cp);
        chk("u8_cycles", bus8.cycles, m8.cy);
        chk("u8_latency", cyc - m8.acc, m8.lat);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  sa, sb;
    int sel, sh;

    bus32.start = 1'b0; bus32.abort = 1'b0; bus32.a_in = '0; bus32.b_in = '0;
    bus8.start  = 1'b0; bus8.abort  = 1'b0; bus8.a_in  = '0; bus8.b_in  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus32.ready, 1);
    chk("rst_done", bus32.done_tick, 0);
    chk("rst_r", bus32.r, 0);
    chk("rst_zero_err", bus32.zero_err, 0);
    chk("rst_coprime", bus32.coprime, 0);
    chk("rst_cycles", bus32.cycles, 0);
    chk("rst8_ready", bus8.ready, 1);
    chk("rst8_r", bus8.r, 0);
    reset = 1'b0;

    // Load a nonzero result, then reset for 2 cycles mid-OP.
    issue32(17, 5, mk(1, 0, 1, 8, 9), 1);
    drain32();
    issue32(48, 18, mk(0, 0, 0, 0, 0), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midop_rst_ready", bus32.ready, 1);
    chk("midop_rst_r", bus32.r, 0);
    chk("midop_rst_coprime", bus32.coprime, 0);
    chk("midop_rst_cycles", bus32.cycles, 0);
    @(negedge clk);
    chk("post_rst_ready", bus32.ready, 1);
    chk("post_rst_done", bus32.done_tick, 0);

    // Directed W=32 cases.
    issue32(48, 18, mk(6, 0, 0, 7, 8), 1);
    issue32(17, 5, mk(1, 0, 1, 8, 9), 1);
    issue32(0, 20, mk(20, 0, 0, 0, 1), 1);
    issue32(0, 0, mk(0, 1, 0, 0, 1), 1);
    issue32(1, 0, mk(1, 0, 1, 0, 1), 1);
    drain32();

    // Abort in the 3rd OP cycle: no completion, result kept, ready next cycle.
    issue32(48, 18, mk(0, 0, 0, 0, 0), 0);
    repeat (2) @(negedge clk);
    bus32.abort = 1'b1;
    @(negedge clk);
    bus32.abort = 1'b0;
    chk("abort_ready", bus32.ready, 1);
    chk("abort_done", bus32.done_tick, 0);
    chk("abort_r_kept", bus32.r, 1);
    chk("abort_coprime_kept", bus32.coprime, 1);
    repeat (10) @(negedge clk);

    // start together with abort in IDLE: start wins; abort dropped before OP.
    bus32.abort = 1'b1;
    issue32(9, 6, mk(3, 0, 0, 4, 5), 1);
    bus32.abort = 1'b0;
    drain32();

    // Start re-pulsed during OP and during DONE is ignored.
    issue32(48, 18, mk(6, 0, 0, 7, 8), 1);
    repeat (2) @(negedge clk);
    bus32.start = 1'b1; bus32.a_in = 9; bus32.b_in = 3;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_done_c8", bus32.done_tick, 1);
    bus32.start = 1'b1; bus32.a_in = 7; bus32.b_in = 7;
    @(negedge clk);
    bus32.start = 1'b0;
    chk("ign_ready_c9", bus32.ready, 1);
    repeat (20) @(negedge clk);
    chk("ign_r_held", bus32.r, 6);
    drain32();

    // Random W=32 regression.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) ra = '0;
      if (sel == 1) rb = '0;
      if (sel == 2) begin
        sh = $urandom_range(0, 12);
        ra = ra >> 12; rb = rb >> 12;
        ra = ra << sh; rb = rb << sh;
      end
      if (sel == 3) rb = ra;
      issue32(ra, rb, model(ra, rb, 16), 1);
    end
    drain32();

    // Directed W=8 cases, including counter saturation at CNT_W=4.
    issue8(128, 64, mk(64, 0, 0, 8, 9));
    issue8(255, 255, mk(255, 0, 0, 1, 2));
    issue8(255, 2, mk(1, 0, 1, 15, 17));
    issue8(0, 0, mk(0, 1, 0, 0, 1));
    drain8();

    // Random W=8 regression.
    for (int i = 0; i < 400; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) sb = sa;
      issue8(sa, sb, model(sa, sb, 4));
    end
    drain8();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
